// File: rtl/sram_ctl_pkg.sv
// Shared definitions for the SRAM packet-buffer controllers: sizes, FSM
// encoding and the WRR weight normalisation rule.
package sram_ctl_pkg;

   localparam int unsigned num_of_queues  = 8;
   localparam int unsigned priority_width = 3;
   localparam int unsigned weight_width   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } sched_state_t;

   // A zero weight would starve a queue forever, so it counts as one.
   function automatic logic [weight_width-1:0] eff_weight(input logic [weight_width-1:0] w);
      return (w == '0) ? weight_width'(1) : w;
   endfunction

endpackage

// File: rtl/sram_rd_scheduler_if.sv
// Scheduler <-> read engine / queue status bundle.
interface sram_rd_scheduler_if;

   logic                                                         sp0_wrr1;
   logic [sram_ctl_pkg::num_of_queues-1:0]                       q_nonempty;
   logic [sram_ctl_pkg::num_of_queues*sram_ctl_pkg::weight_width-1:0] wrr_weights;
   logic                                                         rd_ready;
   logic                                                         rd_done;
   logic                                                         rd_req;
   logic [sram_ctl_pkg::priority_width-1:0]                      rd_queue;
   logic                                                         busy;

   modport master (
      input  sp0_wrr1, q_nonempty, wrr_weights, rd_ready, rd_done,
      output rd_req, rd_queue, busy
   );

   modport slave (
      output sp0_wrr1, q_nonempty, wrr_weights, rd_ready, rd_done,
      input  rd_req, rd_queue, busy
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping modulo n (n must be a power of two).
module rr_pick #(
   parameter int unsigned n = 8,
   parameter int unsigned w = 3
) (
   input  logic [n-1:0] req,
   input  logic [w-1:0] ptr,
   output logic         found,
   output logic [w-1:0] idx
);

   logic [w-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = ptr;
      cand  = ptr;
      for (int unsigned i = 0; i < n; i++) begin
         cand = ptr + w'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/sram_rd_scheduler.sv
// Per-output-port dequeue scheduler: SP or WRR queue selection, one
// packet-read command outstanding at a time.
module sram_rd_scheduler
   import sram_ctl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   sram_rd_scheduler_if.master  bus
);

   sched_state_t                state;
   logic                        rd_req_q;
   logic [priority_width-1:0]   rd_queue_q;
   logic                        busy_q;
   logic [priority_width-1:0]   rr_ptr;
   logic [weight_width-1:0]     credit [num_of_queues];
   logic [weight_width-1:0]     weight [num_of_queues];

   logic [num_of_queues-1:0]    elig_raw;
   logic [num_of_queues-1:0]    elig;
   logic                        reload;
   logic                        wrr_found;
   logic [priority_width-1:0]   wrr_idx;
   logic                        sp_found;
   logic [priority_width-1:0]   sp_idx;
   logic                        grant_valid;
   logic [weight_width-1:0]     grant_credit;

   // Normalised weights and credit-based eligibility.
   always_comb begin
      for (int unsigned q = 0; q < num_of_queues; q++) begin
         weight[q]   = eff_weight(bus.wrr_weights[q*weight_width +: weight_width]);
         elig_raw[q] = bus.q_nonempty[q] && (credit[q] != '0);
      end
   end

   assign reload = (elig_raw == '0) && (bus.q_nonempty != '0);
   assign elig   = reload ? bus.q_nonempty : elig_raw;

   rr_pick #(
      .n (num_of_queues),
      .w (priority_width)
   ) u_rr_pick (
      .req   (elig),
      .ptr   (rr_ptr),
      .found (wrr_found),
      .idx   (wrr_idx)
   );

   // Strict priority: highest nonempty index wins.
   always_comb begin
      sp_found = 1'b0;
      sp_idx   = '0;
      for (int unsigned i = 0; i < num_of_queues; i++) begin
         if (bus.q_nonempty[i]) begin
            sp_found = 1'b1;
            sp_idx   = priority_width'(i);
         end
      end
   end

   assign grant_valid  = bus.sp0_wrr1 ? wrr_found : sp_found;
   assign grant_credit = (reload ? weight[wrr_idx] : credit[wrr_idx]) - weight_width'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rd_req_q   <= 1'b0;
         rd_queue_q <= '0;
         busy_q     <= 1'b0;
         rr_ptr     <= '0;
         for (int unsigned q = 0; q < num_of_queues; q++) credit[q] <= weight[q];
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  state    <= ISSUE;
                  rd_req_q <= 1'b1;
                  busy_q   <= 1'b1;
                  if (bus.sp0_wrr1) begin
                     rd_queue_q <= wrr_idx;
                     if (reload) begin
                        for (int unsigned q = 0; q < num_of_queues; q++) credit[q] <= weight[q];
                     end
                     credit[wrr_idx] <= grant_credit;
                     // Exhausted queue yields; otherwise it keeps the pointer.
                     rr_ptr <= (grant_credit == '0) ? wrr_idx + priority_width'(1) : wrr_idx;
                  end else begin
                     rd_queue_q <= sp_idx;
                  end
               end
            end
            ISSUE: begin
               if (bus.rd_ready) begin
                  state    <= WAIT;
                  rd_req_q <= 1'b0;
               end
            end
            WAIT: begin
               if (bus.rd_done) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               rd_req_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_req   = rd_req_q;
   assign bus.rd_queue = rd_queue_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sram_rd_scheduler.sv
// Directed bench for sram_rd_scheduler with a queue-level reference model.
module tb_sram_rd_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] weights;
   bit          chk_en = 1'b0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   sram_rd_scheduler_if bus();
   assign bus.wrr_weights = weights;

   sram_rd_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int wv(input int q);
      return int'((weights >> (4 * q)) & 32'hF);
   endfunction

   function automatic int eff(input int w);
      return (w == 0) ? 1 : w;
   endfunction

   // Reference model: phase 0 idle, 1 command offered, 2 packet in flight.
   int m_phase, m_queue, m_ptr, m_g, m_live;
   int m_credit [8];
   bit m_req, m_busy;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_req = 0; m_queue = 0; m_busy = 0; m_ptr = 0;
         for (int q = 0; q < 8; q++) m_credit[q] = eff(wv(q));
      end else begin
         case (m_phase)
            0: if (bus.q_nonempty != 0) begin
               m_g = -1;
               if (!bus.sp0_wrr1) begin
                  for (int q = 7; q >= 0; q--) if (m_g < 0 && bus.q_nonempty[q]) m_g = q;
               end else begin
                  m_live = 0;
                  for (int q = 0; q < 8; q++) if (bus.q_nonempty[q] && m_credit[q] > 0) m_live++;
                  if (m_live == 0) for (int q = 0; q < 8; q++) m_credit[q] = eff(wv(q));
                  for (int k = 0; k < 8; k++)
                     if (m_g < 0 && bus.q_nonempty[(m_ptr + k) % 8] && m_credit[(m_ptr + k) % 8] > 0)
                        m_g = (m_ptr + k) % 8;
                  m_credit[m_g] = m_credit[m_g] - 1;
                  m_ptr = (m_credit[m_g] == 0) ? (m_g + 1) % 8 : m_g;
               end
               m_queue = m_g; m_req = 1; m_busy = 1; m_phase = 1;
            end
            1: if (bus.rd_ready) begin m_req = 0; m_phase = 2; end
            2: if (bus.rd_done) begin m_busy = 0; m_phase = 0; end
            default: m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rd_req", int'(bus.rd_req), int'(m_req));
         chk("rd_queue", int'(bus.rd_queue), m_queue);
         chk("busy", int'(bus.busy), int'(m_busy));
      end
   end

   task automatic do_reset(input logic [31:0] w);
      weights = w;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Engine side of one command: accept after ready_delay stalled cycles,
   // then signal eop done_delay cycles later. cfg_* < 0 means no change.
   task automatic serve(input int ready_delay, input int done_delay, input int exp_q,
                        input int cfg_mode, input int cfg_ne, input bit rst_in_wait = 1'b0);
      int n = 0;
      int q0;
      while (!bus.rd_req && n < 20) begin @(negedge clk); n++; end
      if (!bus.rd_req) begin
         checks++; errors++;
         $display("FAIL cmd_timeout: rd_req=0 after %0d cycles, required 1", n);
         return;
      end
      chk("grant", int'(bus.rd_queue), exp_q);
      chk("model_grant", m_queue, exp_q);
      q0 = int'(bus.rd_queue);
      bus.rd_ready = (ready_delay == 0);
      for (int i = 0; i < ready_delay; i++) begin
         bus.rd_done = (i == 1);
         @(negedge clk);
         chk("bp_req", int'(bus.rd_req), 1);
         chk("bp_queue", int'(bus.rd_queue), q0);
      end
      bus.rd_done  = 1'b0;
      bus.rd_ready = 1'b1;
      @(negedge clk);
      bus.rd_ready = 1'b0;
      chk("req_drop", int'(bus.rd_req), 0);
      chk("busy_wait", int'(bus.busy), 1);
      if (cfg_mode >= 0) bus.sp0_wrr1 = cfg_mode[0];
      if (cfg_ne >= 0) bus.q_nonempty = 8'(cfg_ne);
      if (rst_in_wait) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         chk("rst_busy", int'(bus.busy), 0);
         chk("rst_req", int'(bus.rd_req), 0);
         return;
      end
      repeat (done_delay - 1) @(negedge clk);
      bus.rd_done = 1'b1;
      @(negedge clk);
      bus.rd_done = 1'b0;
   endtask

   int wrr_seq [6] = '{0, 0, 1, 0, 0, 1};
   int w0_seq  [4] = '{3, 4, 3, 4};

   initial begin
      rst = 1'b1;
      weights = 32'h1111_1111;
      bus.sp0_wrr1 = 1'b0;
      bus.q_nonempty = '0;
      bus.rd_ready = 1'b0;
      bus.rd_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_req", int'(bus.rd_req), 0);
      chk("reset_queue", int'(bus.rd_queue), 0);
      chk("reset_busy", int'(bus.busy), 0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Strict priority, one-cycle latency, then lower queue after q5 drains.
      bus.q_nonempty = 8'b0010_0100;
      @(negedge clk);
      chk("sp_latency", int'(bus.rd_req), 1);
      serve(0, 3, 5, -1, 8'b0000_0100);
      serve(0, 3, 2, -1, 0);
      repeat (3) @(negedge clk);

      // WRR q0=2, q1=1 with reload after the third grant.
      do_reset(32'h0000_0012);
      bus.sp0_wrr1 = 1'b1;
      bus.q_nonempty = 8'b0000_0011;
      for (int i = 0; i < 6; i++) serve(0, 3, wrr_seq[i], -1, (i == 5) ? 0 : -1);
      repeat (3) @(negedge clk);

      // Backpressure for five cycles, stray rd_done in ISSUE ignored.
      do_reset(32'h1111_1111);
      bus.sp0_wrr1 = 1'b0;
      bus.q_nonempty = 8'b0100_0000;
      serve(5, 3, 6, -1, 0);
      repeat (3) @(negedge clk);

      // Zero weights behave as one.
      do_reset(32'h1110_0111);
      bus.sp0_wrr1 = 1'b1;
      bus.q_nonempty = 8'b0001_1000;
      for (int i = 0; i < 4; i++) serve(0, 2, w0_seq[i], -1, (i == 3) ? 0 : -1);
      repeat (3) @(negedge clk);

      // Reset while WAIT restores credits and pointer.
      do_reset(32'h0000_0011);
      bus.sp0_wrr1 = 1'b1;
      bus.q_nonempty = 8'b0000_0011;
      serve(0, 3, 0, -1, -1, 1'b1);
      serve(0, 3, 0, -1, 0);
      repeat (3) @(negedge clk);

      // Mode switch in WAIT: SP grant in between leaves WRR state untouched.
      do_reset(32'h3000_0003);
      bus.sp0_wrr1 = 1'b1;
      bus.q_nonempty = 8'b1000_0001;
      serve(0, 3, 0, 0, -1);
      serve(0, 3, 7, 1, -1);
      serve(0, 3, 0, -1, 0);
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
